setpoint_entry: RTL and testbench
=================================

SETPOINT_ENTRY -- requirements
Module: setpoint_entry

Interface
REQ-001 Parameter N, default 5, setpoint width in bits; drives the comparator threshold input directly.
REQ-002 Parameter MAX_SP, default 31, largest committable setpoint in degrees; SHALL be at most 2^N-1.
REQ-003 Parameter RESET_SP, default 25, setpoint value loaded at reset.
REQ-004 Clocking is decided: one clock, and reset is synchronous and active-high.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key_valid  input  1  one-cycle strobe; key_code is valid this cycle; back-to-back strobes are separate events.
REQ-008 key_code  input  8  PS/2 set-2 scan code byte from the keyboard receiver.
REQ-009 setpoint  output  N  committed temperature threshold, registered.
REQ-010 setpoint_valid  output  1  registered level; high once any entry has been committed since reset.
REQ-011 entry_err  output  1  one-cycle pulse flagging a rejected entry.
REQ-012 busy  output  1  high while one or more uncommitted digits are held.

Function
REQ-013 Digit codes SHALL be 0=45h, 1=16h, 2=1Eh, 3=26h, 4=25h, 5=2Eh, 6=36h, 7=3Dh, 8=3Eh, 9=46h.
REQ-014 Control codes SHALL be Enter=5Ah, Backspace=66h, Esc=76h, break prefix=F0h, extended prefix=E0h.
REQ-015 FSM states SHALL be WAIT0 (no digits), WAIT1 (d1 held) and WAIT2 (d1 and d2 held); busy=1 in WAIT1 and WAIT2.
REQ-016 An independent brk flag SHALL be set by F0h.
REQ-017 While brk is set, the next strobed code, whatever it is, SHALL be discarded and brk cleared.
REQ-018 E0h SHALL be ignored without touching brk, so that E0 5A acts as Enter and E0 F0 5A is discarded.
REQ-019 A digit in WAIT0 SHALL store d1 and move to WAIT1.
REQ-020 A digit in WAIT1 SHALL store d2 and move to WAIT2.
REQ-021 A digit in WAIT2 SHALL be dropped, pulse entry_err, and leave the state unchanged.
REQ-022 Enter in WAIT1 SHALL evaluate value=d1.
REQ-023 Enter in WAIT2 SHALL evaluate value=10*d1+d2, computed 7 bits wide with no truncation before the range check.
REQ-024 If value<=MAX_SP, setpoint SHALL take value[N-1:0] and setpoint_valid SHALL go 1, both visible the cycle after the Enter strobe.
REQ-025 If value>MAX_SP, entry_err SHALL pulse the cycle after the Enter strobe and setpoint SHALL be unchanged.
REQ-026 In both Enter outcomes the FSM SHALL return to WAIT0 and clear the digit registers.
REQ-027 Enter in WAIT0 SHALL have no effect and SHALL NOT pulse entry_err.
REQ-028 Backspace SHALL move WAIT2->WAIT1 (d2 cleared), WAIT1->WAIT0 (d1 cleared), and do nothing in WAIT0.
REQ-029 Esc SHALL return to WAIT0 from any state with digits cleared; setpoint and setpoint_valid are unchanged.
REQ-030 All other codes SHALL be ignored.
REQ-031 entry_err SHALL be registered and high for exactly one cycle per rejected event.
REQ-032 With key_valid low, no state or output other than entry_err (which returns to 0) SHALL change.

Reset
REQ-033 When reset=1 at a clock edge: setpoint=RESET_SP, setpoint_valid=0, entry_err=0, busy=0, FSM=WAIT0, brk=0, and d1=d2=0.
REQ-034 Reset SHALL take priority over a simultaneous key_valid, and that key event SHALL be lost.
REQ-035 Reset mid-entry (WAIT1/WAIT2 or brk set) SHALL discard pending digits with no commit and no entry_err.

Verification
REQ-036 Reset, no keys -> setpoint=25, setpoint_valid=0, busy=0, entry_err never asserted.
REQ-037 Keys 1Eh, 3Dh, 5Ah -> cycle after 5Ah: setpoint=27, setpoint_valid=1, busy=0.
REQ-038 Keys 26h, 1Eh, 5Ah (32) -> entry_err pulses exactly once and setpoint holds its previous value.
REQ-039 Keys 16h, F0h, 16h, 36h, E0h, 5Ah -> setpoint=16, confirming the break-discarded repeat and E0-prefixed Enter.
REQ-040 Keys 16h, 2Eh, 66h, 26h, 5Ah -> setpoint=13; a separate entry of 16h, 76h, 5Ah -> no change, no error.
REQ-041 Keys 16h, 16h, 16h -> entry_err on the third digit; a following 5Ah commits 11.
REQ-042 Keys 16h then reset asserted together with a 5Ah strobe -> setpoint=25, setpoint_valid=0, busy=0.

Source files
------------

// File: rtl/setpoint_entry.sv
// Keypad-style setpoint entry: decodes PS/2 set-2 scan codes into a one- or
// two-digit decimal value and commits it as the comparator threshold on Enter.
module setpoint_entry #(
  parameter int N        = 5,
  parameter int MAX_SP   = 31,
  parameter int RESET_SP = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [7:0]   key_code,
  output logic [N-1:0] setpoint,
  output logic         setpoint_valid,
  output logic         entry_err,
  output logic         busy
);

  localparam logic [1:0] WAIT0 = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] WAIT2 = 2'd2;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  localparam logic [31:0] MAX_W = 32'(MAX_SP);

  // Scan codes for digits 9..0, so digit k sits at bits [8k +: 8].
  localparam logic [79:0] DIGIT_CODES = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                         8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};

  logic [1:0]   state_reg, state_next;
  logic         brk_reg, brk_next;
  logic [3:0]   d1_reg, d1_next;
  logic [3:0]   d2_reg, d2_next;
  logic [N-1:0] setpoint_reg, setpoint_next;
  logic         valid_reg, valid_next;
  logic         err_reg, err_next;

  logic [9:0]   digit_hit;
  logic [3:0]   digit_val;
  logic         is_digit;
  logic [6:0]   value;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_digit
      assign digit_hit[gi] = (key_code == DIGIT_CODES[gi*8 +: 8]);
    end
  endgenerate

  always_comb begin
    digit_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (digit_hit[i]) digit_val = 4'(i);
    end
  end

  assign is_digit = |digit_hit;

  // Seven bits hold 99, so an out-of-range entry is never wrapped into range.
  assign value = (state_reg == WAIT2) ? (7'(d1_reg) * 7'd10 + 7'(d2_reg))
                                      : 7'(d1_reg);

  always_comb begin
    state_next    = state_reg;
    brk_next      = brk_reg;
    d1_next       = d1_reg;
    d2_next       = d2_reg;
    setpoint_next = setpoint_reg;
    valid_next    = valid_reg;
    err_next      = 1'b0;
    if (key_valid) begin
      if (brk_reg) begin
        brk_next = 1'b0;
      end else if (key_code == KEY_BRK) begin
        brk_next = 1'b1;
      end else if (key_code == KEY_EXT) begin
        brk_next = brk_reg;
      end else if (is_digit) begin
        case (state_reg)
          WAIT0: begin
            d1_next    = digit_val;
            state_next = WAIT1;
          end
          WAIT1: begin
            d2_next    = digit_val;
            state_next = WAIT2;
          end
          default: err_next = 1'b1;
        endcase
      end else if (key_code == KEY_ENTER) begin
        if (state_reg != WAIT0) begin
          if ({25'd0, value} <= MAX_W) begin
            setpoint_next = N'(value);
            valid_next    = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = WAIT0;
          d1_next    = 4'd0;
          d2_next    = 4'd0;
        end
      end else if (key_code == KEY_BKSP) begin
        if (state_reg == WAIT2) begin
          state_next = WAIT1;
          d2_next    = 4'd0;
        end else if (state_reg == WAIT1) begin
          state_next = WAIT0;
          d1_next    = 4'd0;
        end
      end else if (key_code == KEY_ESC) begin
        state_next = WAIT0;
        d1_next    = 4'd0;
        d2_next    = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= WAIT0;
      brk_reg      <= 1'b0;
      d1_reg       <= 4'd0;
      d2_reg       <= 4'd0;
      setpoint_reg <= N'(RESET_SP);
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      brk_reg      <= brk_next;
      d1_reg       <= d1_next;
      d2_reg       <= d2_next;
      setpoint_reg <= setpoint_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
    end
  end

  assign setpoint       = setpoint_reg;
  assign setpoint_valid = valid_reg;
  assign entry_err      = err_reg;
  assign busy           = (state_reg != WAIT0);

endmodule

// File: tb/tb_setpoint_entry.sv
// Directed vectors for setpoint_entry: one clock per row, outputs checked
// just after the edge that consumed the row's inputs.
module tb_setpoint_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic [4:0] setpoint;
  logic       setpoint_valid;
  logic       entry_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       kv;
    logic [7:0] code;
    logic [4:0] sp;
    logic       v;
    logic       b;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  setpoint_entry #(.N(5), .MAX_SP(31), .RESET_SP(25)) dut (
    .clk            (clk),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .setpoint       (setpoint),
    .setpoint_valid (setpoint_valid),
    .entry_err      (entry_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic kv, input logic [7:0] c,
                     input logic [4:0] sp, input logic v, input logic b, input logic e);
    vec_t t;
    t.rst = r; t.kv = kv; t.code = c; t.sp = sp; t.v = v; t.b = b; t.e = e;
    vecs.push_back(t);
  endtask

  task automatic key(input logic [7:0] c, input logic [4:0] sp, input logic v,
                     input logic b, input logic e);
    add(1'b0, 1'b1, c, sp, v, b, e);
  endtask

  task automatic step(input logic r, input logic kv, input logic [7:0] c);
    @(negedge clk);
    reset = r; key_valid = kv; key_code = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int pulses;
    // reset and idle
    add(1'b1, 1'b0, 8'h00, 5'd25, 0, 0, 0);
    add(1'b0, 1'b0, 8'h00, 5'd25, 0, 0, 0);
    // 2,7,Enter -> 27
    key(8'h1E, 5'd25, 0, 1, 0);
    key(8'h3D, 5'd25, 0, 1, 0);
    key(8'h5A, 5'd27, 1, 0, 0);
    add(1'b0, 1'b0, 8'h00, 5'd27, 1, 0, 0);
    // 3,2,Enter -> 32 rejected
    key(8'h26, 5'd27, 1, 1, 0);
    key(8'h1E, 5'd27, 1, 1, 0);
    key(8'h5A, 5'd27, 1, 0, 1);
    add(1'b0, 1'b0, 8'h00, 5'd27, 1, 0, 0);
    // 1, break-1 discarded, 6, E0 Enter -> 16
    key(8'h16, 5'd27, 1, 1, 0);
    key(8'hF0, 5'd27, 1, 1, 0);
    key(8'h16, 5'd27, 1, 1, 0);
    key(8'h36, 5'd27, 1, 1, 0);
    key(8'hE0, 5'd27, 1, 1, 0);
    key(8'h5A, 5'd16, 1, 0, 0);
    // 1,5,Bksp,3,Enter -> 13
    key(8'h16, 5'd16, 1, 1, 0);
    key(8'h2E, 5'd16, 1, 1, 0);
    key(8'h66, 5'd16, 1, 1, 0);
    key(8'h26, 5'd16, 1, 1, 0);
    key(8'h5A, 5'd13, 1, 0, 0);
    // 1,Esc,Enter -> nothing
    key(8'h16, 5'd13, 1, 1, 0);
    key(8'h76, 5'd13, 1, 0, 0);
    key(8'h5A, 5'd13, 1, 0, 0);
    // third digit rejected, then commit 11
    key(8'h16, 5'd13, 1, 1, 0);
    key(8'h16, 5'd13, 1, 1, 0);
    key(8'h16, 5'd13, 1, 1, 1);
    key(8'h5A, 5'd11, 1, 0, 0);
    // E0 F0 5A discarded, then a plain Enter commits 1
    key(8'h16, 5'd11, 1, 1, 0);
    key(8'hE0, 5'd11, 1, 1, 0);
    key(8'hF0, 5'd11, 1, 1, 0);
    key(8'h5A, 5'd11, 1, 1, 0);
    key(8'h5A, 5'd1,  1, 0, 0);
    // boundary 31 accepted, 99 rejected, 0 accepted
    key(8'h26, 5'd1,  1, 1, 0);
    key(8'h16, 5'd1,  1, 1, 0);
    key(8'h5A, 5'd31, 1, 0, 0);
    key(8'h5A, 5'd31, 1, 0, 0);
    key(8'h66, 5'd31, 1, 0, 0);
    key(8'h1C, 5'd31, 1, 0, 0);
    key(8'h46, 5'd31, 1, 1, 0);
    key(8'h46, 5'd31, 1, 1, 0);
    key(8'h5A, 5'd31, 1, 0, 1);
    key(8'h45, 5'd31, 1, 1, 0);
    key(8'h5A, 5'd0,  1, 0, 0);
    // reset wins over a simultaneous Enter
    key(8'h16, 5'd0,  1, 1, 0);
    add(1'b1, 1'b1, 8'h5A, 5'd25, 0, 0, 0);
    add(1'b0, 1'b0, 8'h00, 5'd25, 0, 0, 0);
    // reset clears a pending break; reset in WAIT2 raises no error
    key(8'hF0, 5'd25, 0, 0, 0);
    add(1'b1, 1'b0, 8'h00, 5'd25, 0, 0, 0);
    key(8'h16, 5'd25, 0, 1, 0);
    key(8'h5A, 5'd1,  1, 0, 0);
    key(8'h16, 5'd1,  1, 1, 0);
    key(8'h16, 5'd1,  1, 1, 0);
    add(1'b1, 1'b0, 8'h00, 5'd25, 0, 0, 0);
    add(1'b0, 1'b0, 8'h00, 5'd25, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].kv, vecs[i].code);
      $display("row %0d rst=%0b kv=%0b code=%02h -> sp=%0d v=%0b busy=%0b err=%0b",
               i, vecs[i].rst, vecs[i].kv, vecs[i].code, setpoint, setpoint_valid, busy, entry_err);
      chk("setpoint", i, int'(setpoint), int'(vecs[i].sp));
      chk("setpoint_valid", i, int'(setpoint_valid), int'(vecs[i].v));
      chk("busy", i, int'(busy), int'(vecs[i].b));
      chk("entry_err", i, int'(entry_err), int'(vecs[i].e));
    end

    // long idle after reset: entry_err must stay low, setpoint held
    pulses = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (entry_err) pulses++;
    end
    $display("idle after reset: sp=%0d err_pulses=%0d", setpoint, pulses);
    chk("idle_err_pulses", 0, pulses, 0);
    chk("idle_setpoint", 0, int'(setpoint), 25);

    // rejected 32 gives exactly one error pulse across the following cycles
    pulses = 0;
    step(1'b0, 1'b1, 8'h26);
    step(1'b0, 1'b1, 8'h1E);
    step(1'b0, 1'b1, 8'h5A);
    if (entry_err) pulses++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (entry_err) pulses++;
    end
    $display("reject 32: sp=%0d err_pulses=%0d", setpoint, pulses);
    chk("reject_pulses", 0, pulses, 1);
    chk("reject_setpoint", 0, int'(setpoint), 25);
    chk("reject_valid", 0, int'(setpoint_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
